down_counter_sync_tff: RTL and testbench

- Synchronous binary down counter built from T flip-flops. It is the count-down companion to the up counter in the counters library.
- All bits clock on the same clk edge. Each bit's toggle input is decoded from the lower bits being all zero.
- Adds enable, parallel load, terminal-count and borrow outputs, so it can serve as a programmable divider or timeout timer.

---
 rtl/down_counter_sync_tff.sv | 127 ++++++++++++
 tb/tb_down_counter_sync_tff.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_sync_tff.sv
// -----------------------------------------------------------------------------
// down_counter_sync_tff
//
// Synchronous binary down counter built from one T flip-flop per bit. Every
// flop is clocked by clk; each bit's toggle is decoded from the lower bits
// being all zero (count mode) or from q ^ d (load mode). Adds enable,
// parallel load, a combinational terminal count and a registered borrow pulse.
//
// Parameters:
//   WIDTH  counter width in bits (2..16)
//   WRAP   1: underflow wraps 0 -> all-ones (borrow pulses)
//          0: saturate at 0 (borrow never asserts)
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-low reset (q -> all-ones, borrow -> 0)
//   en      in   count enable, decrement by one per edge
//   load    in   synchronous parallel load, overrides en
//   d       in   parallel load value (only sampled when load=1)
//   q       out  registered count
//   tc      out  combinational terminal count, 1 when q == 0
//   borrow  out  registered one-cycle pulse on a 0 -> wrap transition
//
// Optional build macro:
//   DOWN_COUNTER_RELOAD_EN  adds a reload register (reset to all-ones,
//                           captured from d on every load). On a wrap, q takes
//                           the reload value instead of all-ones, making the
//                           block a divide-by-(N+1) counter. WRAP=0 saturation
//                           still has priority.
// -----------------------------------------------------------------------------
module down_counter_sync_tff #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             borrow
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] t;
  logic             borrow_q;
  logic             borrow_d;

  // zero_chain[i] is 1 when q_q[i-1:0] are all zero; zero_chain[0] is the
  // empty product. This is the classic synchronous T-counter carry chain.
  logic [WIDTH:0]   zero_chain;
  logic             is_zero;

  assign zero_chain[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    assign zero_chain[i+1] = zero_chain[i] & ~q_q[i];
  end

  assign is_zero = zero_chain[WIDTH];

`ifdef DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;

  always_comb begin
    reload_d = reload_q;
    if (load) begin
      reload_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_q <= '1;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  // Toggle decode. Priority: load, then enabled count, else hold.
  always_comb begin
    t        = '0;
    borrow_d = 1'b0;
    if (load) begin
      // Toggling exactly the differing bits lands q on d in one edge.
      t = q_q ^ d;
    end else if (en) begin
      if (is_zero && !WRAP) begin
        // Saturate: suppress every toggle so q stays at 0.
        t = '0;
      end else begin
        // At zero every lower-zero term is true, so all bits toggle and the
        // count naturally wraps to all-ones.
        t        = zero_chain[WIDTH-1:0];
        borrow_d = is_zero;
`ifdef DOWN_COUNTER_RELOAD_EN
        // q is all zero here, so toggling the reload pattern yields it.
        if (is_zero) begin
          t = reload_q;
        end
`endif
      end
    end
  end

  // Each bit is a T flip-flop: next = current XOR toggle.
  assign q_d = q_q ^ t;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q      <= '1;
      borrow_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      borrow_q <= borrow_d;
    end
  end

  assign q      = q_q;
  assign tc     = is_zero;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_down_counter_sync_tff.sv
// -----------------------------------------------------------------------------
// tb_down_counter_sync_tff
//
// Two instances share all inputs: dut_w (WRAP=1) and dut_s (WRAP=0). The
// driver applies stimulus on the falling edge, advances an integer reference
// model and pushes the expected post-edge outputs into exp_q. The monitor
// wakes after each rising edge (and on an asynchronous reset assertion),
// pops one entry and compares every output of both instances.
// -----------------------------------------------------------------------------
module tb_down_counter_sync_tff;

  localparam int W     = 4;
  localparam int MAXV  = (1 << W) - 1;
  localparam int ENT_W = 2 * (W + 2);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         en   = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] d    = '0;

  logic [W-1:0] q_w, q_s;
  logic         tc_w, tc_s, borrow_w, borrow_s;

  down_counter_sync_tff #(.WIDTH(W), .WRAP(1'b1)) dut_w (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .load   (load),
    .d      (d),
    .q      (q_w),
    .tc     (tc_w),
    .borrow (borrow_w)
  );

  down_counter_sync_tff #(.WIDTH(W), .WRAP(1'b0)) dut_s (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .load   (load),
    .d      (d),
    .q      (q_s),
    .tc     (tc_s),
    .borrow (borrow_s)
  );

  // scoreboard state
  logic [ENT_W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int n_push = 0;
  int n_pop = 0;

  // reference model: plain integer counts
  int m_q_w, m_q_s, m_reload;
  bit m_b_w, m_b_s;

  function automatic logic [ENT_W-1:0] pack_model();
    logic [W-1:0] qw, qs;
    qw = W'(m_q_w);
    qs = W'(m_q_s);
    return {qw, (m_q_w == 0), m_b_w, qs, (m_q_s == 0), m_b_s};
  endfunction

  task automatic model_reset();
    m_q_w    = MAXV;
    m_q_s    = MAXV;
    m_b_w    = 1'b0;
    m_b_s    = 1'b0;
    m_reload = MAXV;
  endtask

  task automatic model_edge(input bit ld, input bit e, input int dv);
    m_b_w = 1'b0;
    m_b_s = 1'b0;
    if (ld) begin
      m_q_w    = dv;
      m_q_s    = dv;
      m_reload = dv;
    end else if (e) begin
      if (m_q_w > 0) begin
        m_q_w = m_q_w - 1;
      end else begin
`ifdef DOWN_COUNTER_RELOAD_EN
        m_q_w = m_reload;
`else
        m_q_w = MAXV;
`endif
        m_b_w = 1'b1;
      end
      if (m_q_s > 0) m_q_s = m_q_s - 1;
    end
  endtask

  task automatic push_exp();
    exp_q.push_back(pack_model());
    n_push++;
  endtask

  // driver tasks
  task automatic step(input bit ld, input bit e, input logic [W-1:0] dv);
    @(negedge clk);
    rst  = 1'b1;
    load = ld;
    en   = e;
    d    = dv;
    model_edge(ld, e, int'(dv));
    push_exp();
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    en   = 1'b0;
    model_reset();
    push_exp();
  endtask

  // Assert reset 2 ns after a rising edge, well before the next one.
  task automatic async_reset();
    @(posedge clk);
    #2;
    model_reset();
    push_exp();
    rst = 1'b0;
  endtask

  task automatic check(input string name, input int got, input int want);
    tests_run++;
    if (got != want) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
    end
  endtask

  // monitor
  initial begin
    logic [ENT_W-1:0] e;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_pop++;
        check("q_wrap",      int'(q_w),      int'(e[ENT_W-1 -: W]));
        check("tc_wrap",     int'(tc_w),     int'(e[W+3]));
        check("borrow_wrap", int'(borrow_w), int'(e[W+2]));
        check("q_sat",       int'(q_s),      int'(e[W+1:2]));
        check("tc_sat",      int'(tc_s),     int'(e[1]));
        check("borrow_sat",  int'(borrow_s), int'(e[0]));
      end
    end
  end

  // stimulus
  initial begin
    model_reset();

    // reset held for two cycles, then count the full range and wrap
    hold_reset();
    hold_reset();
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, '0);

    // asynchronous reset while q = 6
    step(1'b1, 1'b0, 4'd8);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    async_reset();
    hold_reset();

    // load priority over enable, then count down to zero and past it
    step(1'b1, 1'b1, 4'd9);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0);
    // load zero with enable: tc next cycle, no borrow
    step(1'b1, 1'b1, 4'd0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);

    // enable hold pattern from 5
    step(1'b1, 1'b0, 4'd5);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);

    // saturation (dut_s) vs wrap (dut_w) from 2
    step(1'b1, 1'b1, 4'd2);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);

    // reload period from 3
    step(1'b1, 1'b0, 4'd3);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, '0);

    // randomized traffic with occasional async reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
        hold_reset();
      end else begin
        step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
             W'($urandom_range(0, MAXV)));
      end
    end
    step(1'b0, 1'b0, '0);

    // drain: bounded wait for the monitor to consume everything
    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);
    check("pop_count", n_pop, n_push);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
